// File: rtl/div32_seq.sv
// div32_seq: sequential signed integer divider (restoring shift-subtract).
// Produces quotient (to LO) and remainder (to HI) for the DIV instruction.
// The core iterates on unsigned magnitudes for WIDTH cycles, then runs one
// sign-correction cycle. Divide-by-zero skips the core entirely.
//
// Ports:
//   clock        system clock, rising-edge active
//   clear        asynchronous active-high reset
//   start        request, sampled only in IDLE
//   dividend     signed dividend (two's complement)
//   divisor      signed divisor (two's complement)
//   busy         high in CALC and FIX
//   done         one-cycle pulse, results valid
//   quotient     signed quotient, truncated toward zero
//   remainder    signed remainder, same sign as dividend
//   div_by_zero  set alongside done when the divisor was 0
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | waiting for start; outputs hold the last result
// CALC   | one restoring iteration per cycle, WIDTH cycles total
// FIX    | apply operand signs and load quotient/remainder
// DONE   | done pulse for one cycle, start ignored

module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder R
    logic [WIDTH-1:0] work_q, work_d;    // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_q, dvs_d;      // |divisor|
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude.
    assign mag_a = dividend[WIDTH-1] ? -dividend : dividend;
    assign mag_b = divisor[WIDTH-1]  ? -divisor  : divisor;

    // Shifted R can reach WIDTH+1 bits; one extra bit keeps the borrow visible.
    assign shifted = {rem_q, work_q[WIDTH-1]};
    assign trial   = {1'b0, shifted} - {2'b00, dvs_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        work_d    = work_q;
        dvs_d     = dvs_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dbz_d     = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_a_d = dividend[WIDTH-1];
                    sign_b_d = divisor[WIDTH-1];
                    work_d   = mag_a;
                    dvs_d    = mag_b;
                    rem_d    = '0;
                    cnt_d    = CW'(WIDTH - 1);
                    if (divisor == '0) begin
                        quo_out_d = '1;
                        rem_out_d = dividend;
                        dbz_d     = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (trial[WIDTH+1]) begin
                    rem_d  = shifted[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d  = trial[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], 1'b1};
                end
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                quo_out_d = (sign_a_q ^ sign_b_q) ? -work_q : work_q;
                rem_out_d = sign_a_q ? -rem_q : rem_q;
                state_d   = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            work_q    <= '0;
            dvs_q     <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            work_q    <= work_d;
            dvs_q     <= dvs_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
    assign done        = (state_q == S_DONE);
    assign quotient    = quo_out_q;
    assign remainder   = rem_out_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq: directed-vector bench for div32_seq.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Latency is counted in falling edges after the accepting rising edge until
// done is seen: 34 for a normal divide, 1 for divide-by-zero (the rising edge
// after that is where a synchronous consumer captures done).

module tb_div32_seq;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    div32_seq #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One start pulse, wait (bounded) for done, check result and timing.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic [31:0] exp_r,
                           input logic exp_dbz, input int exp_lat, input int exp_busy);
        int cnt;
        int busy_cnt;
        logic got;
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        cnt      = 0;
        busy_cnt = 0;
        got      = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            start = 1'b0;
            cnt++;
            if (busy) busy_cnt++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, cnt, exp_lat);
        check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        check({tag, "_quotient"}, quotient, exp_q);
        check({tag, "_remainder"}, remainder, exp_r);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
        @(negedge clock);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int first_done;
        int second_done;
        logic [31:0] q_cap;
        logic [31:0] r_cap;

        clear    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        clear = 1'b0;

        run_div("pos",      32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34, 33);
        run_div("neg_a",    -32'sd100,      32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 34, 33);
        run_div("neg_b",    32'd100,        -32'sd7,        32'hFFFF_FFF2,  32'd2,          1'b0, 34, 33);
        run_div("neg_ab",   -32'sd100,      -32'sd7,        32'd14,         32'hFFFF_FFFE,  1'b0, 34, 33);
        run_div("ovf",      32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 34, 33);
        run_div("max_1",    32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0, 34, 33);
        run_div("small",    32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 34, 33);
        run_div("min_2",    32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0, 34, 33);
        run_div("m7_2",     -32'sd7,        32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34, 33);
        run_div("dbz",      32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1,  0);
        run_div("after_dbz", 32'd100,       32'd7,          32'd14,         32'd2,          1'b0, 34, 33);

        // Second start while busy is ignored: one done, result of 50/5.
        @(negedge clock);
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        done_cnt = 0;
        q_cap    = '0;
        r_cap    = '0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (i == 10) begin
                dividend = 32'd9;
                divisor  = 32'd3;
                start    = 1'b1;
            end
            if (done) begin
                done_cnt++;
                q_cap = quotient;
                r_cap = remainder;
            end
        end
        check("ignore_done_count", done_cnt, 32'd1);
        check("ignore_quotient", q_cap, 32'd10);
        check("ignore_remainder", r_cap, 32'd0);

        // Operands changed mid-CALC; outputs hold the previous result meanwhile.
        @(negedge clock);
        dividend = 32'd1000;
        divisor  = 32'd10;
        start    = 1'b1;
        done_cnt = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (i == 5) begin
                check("hold_quotient", quotient, 32'd10);
                check("hold_remainder", remainder, 32'd0);
                dividend = 32'hDEAD_BEEF;
                divisor  = 32'd3;
            end
            if (done) begin
                done_cnt++;
                check("midchg_quotient", quotient, 32'd100);
                check("midchg_remainder", remainder, 32'd0);
                break;
            end
        end
        check("midchg_done_count", done_cnt, 32'd1);

        // start held high: back-to-back operations.
        @(negedge clock);
        dividend    = 32'd21;
        divisor     = 32'd4;
        start       = 1'b1;
        first_done  = -1;
        second_done = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            if (done) begin
                if (first_done < 0) begin
                    first_done = i;
                end else begin
                    second_done = i;
                    start = 1'b0;
                    break;
                end
            end
        end
        check("b2b_first_latency", first_done, 32'd34);
        check("b2b_period", second_done - first_done, 32'd35);
        check("b2b_quotient", quotient, 32'd5);
        check("b2b_remainder", remainder, 32'd1);
        repeat (3) @(negedge clock);
        check("b2b_idle_after_release", 32'(busy), 32'd0);

        // Asynchronous clear in the middle of CALC.
        @(negedge clock);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(negedge clock);
        check("pre_clr_busy", 32'(busy), 32'd1);
        #2;
        clear = 1'b1;
        #1;
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_done", 32'(done), 32'd0);
        check("clr_quotient", quotient, 32'd0);
        check("clr_remainder", remainder, 32'd0);
        #1;
        clear = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
        check("clr_no_done", done_cnt, 32'd0);
        run_div("post_clr", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 33);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
